window_gen: RTL and testbench

Parametrised measurement-window generator: the successor to the fixed-length window timer. It produces gated count windows for the ring-oscillator edge counters, with runtime-programmable window length and inter-window gap, continuous or one-shot mode, and a running window index. Completed windows are flagged to the capture/UART path by a one-cycle done pulse.

---
 rtl/window_gen.sv | 143 ++++++++++++++
 tb/tb_window_gen.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_gen.sv
// Measurement-window generator: programmable window/gap lengths, continuous or
// one-shot launch, running window index and a one-cycle done pulse per window.
module window_gen #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned IDX_W       = 16,
  parameter int unsigned DEFAULT_LEN = 10_000,
  parameter int unsigned DEFAULT_GAP = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic             mode,
  input  logic             abort,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_gap,
  output logic             cfg_pending,
  output logic             window_open,
  output logic             window_start,
  output logic             window_done,
  output logic [IDX_W-1:0] window_idx,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, OPEN, GAP} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] act_len, act_gap;
  logic [CNT_W-1:0] pend_len, pend_gap;
  logic             load;     // a window launches at this edge
  logic             done_d;   // a window completes at this edge
  logic             cont_go;  // continuous relaunch allowed
  logic             shot_go;  // one-shot trigger (IDLE only)

  // State and phase counter; cnt counts elapsed cycles of the current OPEN/GAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state: launch, window completion, gap completion; abort overrides all
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    load    = 1'b0;
    done_d  = 1'b0;
    cont_go = !mode && en;
    shot_go = mode && start;
    case (state)
      IDLE: begin
        if (cont_go || shot_go) begin
          state_d = OPEN;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      OPEN: begin
        if (cnt == act_len - CNT_W'(1)) begin
          done_d = 1'b1;
          cnt_d  = '0;
          if (act_gap != '0) begin
            state_d = GAP;
          end else if (cont_go) begin
            state_d = OPEN;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == act_gap - CNT_W'(1)) begin
          cnt_d = '0;
          if (cont_go) begin
            state_d = OPEN;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      load    = 1'b0;
      done_d  = 1'b0;
    end
  end

  // Config: a write always wins over the launch clear, so a same-cycle write
  // stays pending for the following launch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_len    <= CNT_W'(DEFAULT_LEN);
      pend_gap    <= CNT_W'(DEFAULT_GAP);
      act_len     <= CNT_W'(1);
      act_gap     <= '0;
      cfg_pending <= 1'b0;
    end else begin
      if (load) begin
        act_len     <= (pend_len == '0) ? CNT_W'(1) : pend_len;
        act_gap     <= pend_gap;
        cfg_pending <= 1'b0;
      end
      if (cfg_we) begin
        pend_len    <= cfg_len;
        pend_gap    <= cfg_gap;
        cfg_pending <= 1'b1;
      end
    end
  end

  // Registered outputs derived from the decisions made this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_open  <= 1'b0;
      window_start <= 1'b0;
      window_done  <= 1'b0;
      window_idx   <= '0;
      busy         <= 1'b0;
    end else begin
      window_open  <= (state_d == OPEN);
      window_start <= load;
      window_done  <= done_d;
      busy         <= (state_d != IDLE);
      if (done_d) window_idx <= window_idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_window_gen.sv
// Bench for window_gen: directed scenarios plus random stimulus, every cycle
// checked against a countdown-based behavioural model.
module tb_window_gen;

  localparam int CNT_W   = 8;
  localparam int IDX_W   = 2;
  localparam int DEF_LEN = 4;
  localparam int DEF_GAP = 0;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0, start = 1'b0, mode = 1'b0, abort = 1'b0, cfg_we = 1'b0;
  logic [CNT_W-1:0] cfg_len = '0, cfg_gap = '0;
  logic             cfg_pending, window_open, window_start, window_done, busy;
  logic [IDX_W-1:0] window_idx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  window_gen #(.CNT_W(CNT_W), .IDX_W(IDX_W), .DEFAULT_LEN(DEF_LEN), .DEFAULT_GAP(DEF_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .mode(mode), .abort(abort),
    .cfg_we(cfg_we), .cfg_len(cfg_len), .cfg_gap(cfg_gap), .cfg_pending(cfg_pending),
    .window_open(window_open), .window_start(window_start), .window_done(window_done),
    .window_idx(window_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: remaining open cycles / remaining gap cycles of the current window
  int               m_open_left, m_gap_left, m_agap, m_pl, m_pg;
  bit               m_pend, e_start, e_done;
  logic [IDX_W-1:0] m_idx;

  logic [6:0] dut_v, exp_v;
  assign dut_v = {cfg_pending, window_open, window_start, window_done, busy, window_idx};
  assign exp_v = {m_pend, (m_open_left > 0), e_start, e_done,
                  (m_open_left > 0 || m_gap_left > 0), m_idx};

  task automatic model_reset();
    m_open_left = 0; m_gap_left = 0; m_agap = 0;
    m_pl = DEF_LEN; m_pg = DEF_GAP; m_pend = 0; m_idx = '0;
    e_start = 0; e_done = 0;
  endtask

  // Advance the model by one clock using the inputs about to be sampled
  task automatic model_step();
    bit go_cont, launch;
    if (!rst_n) begin
      model_reset();
      return;
    end
    go_cont = !mode && en;
    launch  = 0;
    e_start = 0;
    e_done  = 0;
    if (abort) begin
      m_open_left = 0;
      m_gap_left  = 0;
    end else if (m_open_left > 0) begin
      m_open_left--;
      if (m_open_left == 0) begin
        e_done = 1;
        m_idx  = m_idx + 1'b1;
        m_gap_left = m_agap;
        launch = (m_agap == 0) && go_cont;
      end
    end else if (m_gap_left > 0) begin
      m_gap_left--;
      launch = (m_gap_left == 0) && go_cont;
    end else begin
      launch = go_cont || (mode && start);
    end
    if (launch) begin
      m_open_left = (m_pl == 0) ? 1 : m_pl;
      m_agap  = m_pg;
      e_start = 1;
      m_pend  = 0;
    end
    if (cfg_we) begin
      m_pl = int'(cfg_len);
      m_pg = int'(cfg_gap);
      m_pend = 1;
    end
  endtask

  // One clock: step the model, then land on the falling edge for sampling/driving
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic write_cfg(input int len, input int gap);
    cfg_we = 1; cfg_len = CNT_W'(len); cfg_gap = CNT_W'(gap);
    tick();
    cfg_we = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick(); tick();
    total++;
    if (dut_v !== 7'd0) begin
      bad++; $display("FAIL reset_outputs cyc=%0d got=%b exp=%b", cyc, dut_v, 7'd0);
    end
    rst_n = 1;
    tick();
    total++;
    if (dut_v !== exp_v) begin
      bad++; $display("FAIL reset_release cyc=%0d got=%b exp=%b", cyc, dut_v, exp_v);
    end
  endtask

  // Defaults L=4 G=0: open stays high, start every 4, done with later starts
  task automatic test_back_to_back();
    mode = 0; en = 1;
    for (int k = 0; k < 17; k++) begin
      tick();
      total++;
      if (dut_v !== exp_v) begin
        bad++; $display("FAIL b2b_model k=%0d got=%b exp=%b", k, dut_v, exp_v);
      end
      total++;
      if ({window_open, window_start, window_done, window_idx} !==
          {1'b1, (k % 4 == 0), (k % 4 == 0 && k > 0), IDX_W'(k / 4)}) begin
        bad++; $display("FAIL b2b_pattern k=%0d got=%b%b%b idx=%0d", k,
                        window_open, window_start, window_done, window_idx);
      end
    end
    en = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      total++;
      if (dut_v !== exp_v) begin
        bad++; $display("FAIL b2b_drain k=%0d got=%b exp=%b", k, dut_v, exp_v);
      end
    end
  endtask

  // L=3 G=2 written in IDLE: period 5, done in first gap cycle
  task automatic test_cfg_gap();
    write_cfg(3, 2);
    total++;
    if (cfg_pending !== 1'b1) begin
      bad++; $display("FAIL gap_pending_set got=%b exp=1", cfg_pending);
    end
    en = 1;
    for (int k = 0; k < 15; k++) begin
      tick();
      total++;
      if (dut_v !== exp_v) begin
        bad++; $display("FAIL gap_model k=%0d got=%b exp=%b", k, dut_v, exp_v);
      end
      total++;
      if ({window_open, window_start, window_done, busy, cfg_pending} !==
          {(k % 5 < 3), (k % 5 == 0), (k % 5 == 3), 1'b1, 1'b0}) begin
        bad++; $display("FAIL gap_pattern k=%0d got=%b%b%b%b%b", k,
                        window_open, window_start, window_done, busy, cfg_pending);
      end
    end
    en = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      total++;
      if (dut_v !== exp_v) begin
        bad++; $display("FAIL gap_drain k=%0d got=%b exp=%b", k, dut_v, exp_v);
      end
    end
  endtask

  // One-shot L=5: one window, one done, re-trigger while busy ignored
  task automatic test_oneshot();
    mode = 1; en = 0;
    write_cfg(5, 0);
    start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 10; k++) begin
      total++;
      if (dut_v !== exp_v) begin
        bad++; $display("FAIL shot_model k=%0d got=%b exp=%b", k, dut_v, exp_v);
      end
      total++;
      if ({window_open, window_start, window_done, busy} !==
          {(k < 5), (k == 0), (k == 5), (k < 5)}) begin
        bad++; $display("FAIL shot_pattern k=%0d got=%b%b%b%b", k,
                        window_open, window_start, window_done, busy);
      end
      start = (k == 2);
      tick();
    end
    start = 0; mode = 0;
  endtask

  // Config write mid-window: current stays 4, next becomes 7
  task automatic test_cfg_midwindow();
    write_cfg(4, 0);
    en = 1;
    for (int k = 0; k < 15; k++) begin
      tick();
      cfg_we = 0;
      total++;
      if (dut_v !== exp_v) begin
        bad++; $display("FAIL mid_model k=%0d got=%b exp=%b", k, dut_v, exp_v);
      end
      total++;
      if ({window_open, window_start} !== {1'b1, (k == 0 || k == 4 || k == 11)}) begin
        bad++; $display("FAIL mid_pattern k=%0d got=%b%b", k, window_open, window_start);
      end
      if (k == 1) begin
        cfg_we = 1; cfg_len = 8'd7; cfg_gap = 8'd0;
      end
    end
    en = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      total++;
      if (dut_v !== exp_v) begin
        bad++; $display("FAIL mid_drain k=%0d got=%b exp=%b", k, dut_v, exp_v);
      end
    end
  endtask

  // Abort on 2nd open cycle and on last open cycle: no done, idx held
  task automatic test_abort();
    logic [IDX_W-1:0] idx0;
    write_cfg(4, 1);
    idx0 = m_idx;
    en = 1;
    tick();
    tick();
    abort = 1; en = 0;
    tick();
    abort = 0;
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({window_open, window_done, busy, window_idx} !== {3'b000, idx0} || dut_v !== exp_v) begin
        bad++; $display("FAIL abort_mid k=%0d got=%b exp=%b idx0=%0d", k, dut_v, exp_v, idx0);
      end
      tick();
    end
    en = 1;
    tick();
    en = 0;
    tick(); tick(); tick();
    abort = 1;
    tick();
    abort = 0;
    total++;
    if ({window_open, window_done, busy, window_idx} !== {3'b000, idx0} || dut_v !== exp_v) begin
      bad++; $display("FAIL abort_last got=%b exp=%b idx0=%0d", dut_v, exp_v, idx0);
    end
    tick();
    total++;
    if (window_done !== 1'b0 || dut_v !== exp_v) begin
      bad++; $display("FAIL abort_after got=%b exp=%b", dut_v, exp_v);
    end
  endtask

  // Length 0 acts as 1: a window every cycle, idx wraps past 3
  task automatic test_len0_wrap();
    logic [IDX_W-1:0] idx_exp;
    write_cfg(0, 0);
    idx_exp = m_idx + IDX_W'(5);
    en = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if (dut_v !== exp_v || window_start !== 1'b1 || window_open !== 1'b1) begin
        bad++; $display("FAIL len0 k=%0d got=%b exp=%b", k, dut_v, exp_v);
      end
    end
    total++;
    if (window_idx !== idx_exp) begin
      bad++; $display("FAIL idx_wrap got=%0d exp=%0d", window_idx, idx_exp);
    end
    en = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (dut_v !== exp_v) begin
        bad++; $display("FAIL len0_drain k=%0d got=%b exp=%b", k, dut_v, exp_v);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      en     = ($urandom_range(0, 3) != 0);
      mode   = ($urandom_range(0, 3) == 0);
      start  = ($urandom_range(0, 3) == 0);
      abort  = ($urandom_range(0, 19) == 0);
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_len = CNT_W'($urandom_range(0, 6));
      cfg_gap = CNT_W'($urandom_range(0, 3));
      tick();
      total++;
      if (dut_v !== exp_v) begin
        bad++; $display("FAIL random k=%0d got=%b exp=%b", k, dut_v, exp_v);
      end
    end
    en = 0; mode = 0; start = 0; abort = 0; cfg_we = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      total++;
      if (dut_v !== exp_v) begin
        bad++; $display("FAIL random_drain k=%0d got=%b exp=%b", k, dut_v, exp_v);
      end
    end
  endtask

  // Asynchronous reset mid-window; afterwards default length 4 is back
  task automatic test_async_reset();
    write_cfg(6, 0);
    en = 1;
    tick(); tick();
    write_cfg(2, 1);
    #2 rst_n = 0;
    model_reset();
    #1;
    total++;
    if (dut_v !== 7'd0) begin
      bad++; $display("FAIL async_reset got=%b exp=%b", dut_v, 7'd0);
    end
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 9; k++) begin
      tick();
      total++;
      if (dut_v !== exp_v || window_start !== (k % 4 == 0) || cfg_pending !== 1'b0) begin
        bad++; $display("FAIL post_reset k=%0d got=%b exp=%b", k, dut_v, exp_v);
      end
    end
    en = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_back_to_back();
    test_cfg_gap();
    test_oneshot();
    test_cfg_midwindow();
    test_abort();
    test_len0_wrap();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
